ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_if.sv | 24 ++
 rtl/ram_responder.sv | 173 +++++++++++++++++
 tb/tb_ram_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response bundle between an initiator and ram_responder.
// The master drives the request side and observes the response side; the slave
// (the responder) does the opposite. Clock and reset stay plain module ports.
interface ram_responder_if;
  logic        req_re;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_re, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_re, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM plus an 8-bit output register behind a
// two-state request/response handshake (one access every two cycles).
// Optional build macro MISALIGN_CHECK_EN: misaligned halfword/word accesses fault
// instead of having their low address bits silently cleared.
module ram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] IO_ADDR    = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_responder_if.slave   bus,
  output logic [7:0]       io_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [31:0]             r_mem [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0]              r_io_out;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [31:0]             r_rsp_rdata;

  logic                    w_accept;
  logic                    w_is_io;
  logic                    w_both;
  logic                    w_f3_bad;
  logic                    w_err;
  logic [1:0]              w_off;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [3:0]              w_mask;
  logic [31:0]             w_wdata_sh;
  logic                    w_ram_we;
  logic                    w_io_we;
  logic                    w_is_load;
  logic [31:0]             w_load_data;

  // Select the addressed byte/halfword/word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  f_extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  f_extract = {{16{sh[15]}}, sh[15:0]};
      3'b010:  f_extract = sh;
      3'b100:  f_extract = {24'h00_0000, sh[7:0]};
      3'b101:  f_extract = {16'h0000, sh[15:0]};
      default: f_extract = 32'h0000_0000;
    endcase
  endfunction

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] f_lane_mask(input logic [2:0] f3,
                                             input logic [1:0] off);
    case (f3)
      3'b000:  f_lane_mask = 4'b0001 << off;
      3'b001:  f_lane_mask = 4'b0011 << off;
      3'b010:  f_lane_mask = 4'b1111;
      default: f_lane_mask = 4'b0000;
    endcase
  endfunction

  // Request decode: acceptance, fault detection and effective byte offset.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && (bus.req_re || bus.req_we);
    w_is_io  = (bus.req_addr == IO_ADDR);
    w_both   = bus.req_re && bus.req_we;
    w_idx    = bus.req_addr[ADDR_WIDTH+1:2];
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_bad = 1'b0;
      default:                                w_f3_bad = 1'b1;
    endcase
`ifdef MISALIGN_CHECK_EN
    // Misaligned halfword/word accesses are reported as faults.
    w_off = bus.req_addr[1:0];
    w_err = w_both || w_f3_bad ||
            ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    // Misaligned low bits are cleared so the access lands on its natural boundary.
    w_err = w_both || w_f3_bad;
    if (bus.req_funct3[1:0] == 2'b01) begin
      w_off = {bus.req_addr[1], 1'b0};
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      w_off = 2'b00;
    end else begin
      w_off = bus.req_addr[1:0];
    end
`endif
    w_is_load  = bus.req_re && !bus.req_we && !w_err;
    w_ram_we   = w_accept && bus.req_we && !bus.req_re && !w_err && !w_is_io;
    w_io_we    = w_accept && bus.req_we && !bus.req_re && !w_err && w_is_io;
    w_mask     = f_lane_mask(bus.req_funct3, w_off);
    w_wdata_sh = bus.req_wdata << {w_off, 3'b000};
    if (w_is_io) begin
      w_load_data = {24'h00_0000, r_io_out};
    end else begin
      w_load_data = f_extract(r_mem[w_idx], w_off, bus.req_funct3);
    end
  end

  // Next-state logic: every acceptance is followed by exactly one response cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response registers: loaded on acceptance, cleared in every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= w_is_load ? w_load_data : 32'h0000_0000;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end
  end

  // Output register: any-width store to IO_ADDR captures the low data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_out <= 8'h00;
    end else if (w_io_we) begin
      r_io_out <= bus.req_wdata[7:0];
    end
  end

  // RAM byte-lane writes; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign io_out        = r_io_out;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder (default parameters).
module tb_ram_responder;
  logic       clk;
  logic       rst_n;
  logic [7:0] io_out;
  int         checks;
  int         errors;

  ram_responder_if bus_if ();

  ram_responder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .io_out (io_out)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One complete access: drive at negedge, check response after the accepting
  // edge, then check the return to idle after the following edge.
  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input string tag);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.req_re     = re;
    bus_if.req_we     = we;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_funct3 = f3;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, bus_if.rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, bus_if.rsp_rdata, exp_rdata);
    chk({tag, ".err"},   {31'd0, bus_if.rsp_err}, {31'd0, exp_err});
    bus_if.req_re = 1'b0;
    bus_if.req_we = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, {31'd0, bus_if.rsp_valid}, 32'd0);
    chk({tag, ".idle_err"},   {31'd0, bus_if.rsp_err}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.req_re     = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_addr   = 32'h0000_0000;
    bus_if.req_wdata  = 32'h0000_0000;
    bus_if.req_funct3 = 3'b000;
    #12;
    chk("rst.valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("rst.rdata", bus_if.rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, bus_if.rsp_err}, 32'd0);
    chk("rst.io",    {24'd0, io_out}, 32'd0);
    chk("rst.ready", {31'd0, bus_if.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load round trip.
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0, "sw10");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw10");
    // Byte store and sign/zero extension.
    access(1'b0, 1'b1, 32'h0000_0011, 32'h0000_0080, 3'b000, 32'h0000_0000, 1'b0, "sb11");
    access(1'b1, 1'b0, 32'h0000_0011, 32'h0000_0000, 3'b000, 32'hFFFF_FF80, 1'b0, "lb11");
    access(1'b1, 1'b0, 32'h0000_0011, 32'h0000_0000, 3'b100, 32'h0000_0080, 1'b0, "lbu11");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0, "lw10b");

    // Output register and aliasing.
    access(1'b0, 1'b1, 32'h0000_0000, 32'h1122_3344, 3'b010, 32'h0000_0000, 1'b0, "sw0");
    access(1'b0, 1'b1, 32'h8000_0000, 32'h1234_56A5, 3'b010, 32'h0000_0000, 1'b0, "swio");
    chk("io.a5", {24'd0, io_out}, 32'h0000_00A5);
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 3'b010, 32'h1122_3344, 1'b0, "lw0");
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 3'b010, 32'h0000_00A5, 1'b0, "lwio");
    access(1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 3'b010, 32'h1122_3344, 1'b0, "alias0");
    access(1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0, "alias10");

    // Faults: both strobes, illegal funct3.
    access(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1, "both10");
    access(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0077, 3'b010, 32'h0000_0000, 1'b1, "bothio");
    chk("io.keep", {24'd0, io_out}, 32'h0000_00A5);
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 3'b011, 32'h0000_0000, 1'b1, "f3_011");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b110, 32'h0000_0000, 1'b1, "f3_110");
    access(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0055, 3'b111, 32'h0000_0000, 1'b1, "f3_111io");
    chk("io.keep2", {24'd0, io_out}, 32'h0000_00A5);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_80EF, 1'b0, "lw10c");

    // Halfword accesses, aligned and misaligned.
    access(1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 3'b001, 32'hFFFF_DEAD, 1'b0, "lh12");
    access(1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 3'b101, 32'h0000_DEAD, 1'b0, "lhu12");
`ifdef MISALIGN_CHECK_EN
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 3'b001, 32'h0000_0000, 1'b1, "lh13");
`else
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 3'b001, 32'hFFFF_DEAD, 1'b0, "lh13");
`endif
    access(1'b0, 1'b1, 32'h0000_0012, 32'h0000_1234, 3'b001, 32'h0000_0000, 1'b0, "sh12");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h1234_80EF, 1'b0, "lw10d");
`ifdef MISALIGN_CHECK_EN
    access(1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 3'b010, 32'h0000_0000, 1'b1, "sw13");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h1234_80EF, 1'b0, "lw10e");
`else
    access(1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 3'b010, 32'h0000_0000, 1'b0, "sw13");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hCAFE_F00D, 1'b0, "lw10e");
`endif

    // Request held high: accepted on every second edge only.
    @(negedge clk);
    bus_if.req_re     = 1'b1;
    bus_if.req_we     = 1'b0;
    bus_if.req_addr   = 32'h0000_0000;
    bus_if.req_funct3 = 3'b010;
    @(posedge clk); #1;
    chk("b2b.v1", {31'd0, bus_if.rsp_valid}, 32'd1);
    chk("b2b.d1", bus_if.rsp_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    chk("b2b.v2", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("b2b.r2", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b2b.v3", {31'd0, bus_if.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b.v4", {31'd0, bus_if.rsp_valid}, 32'd0);
    bus_if.req_re = 1'b0;

    // Reset in the middle of a load response.
    @(negedge clk);
    bus_if.req_re   = 1'b1;
    bus_if.req_addr = 32'h0000_0000;
    @(posedge clk); #1;
    chk("rr.valid", {31'd0, bus_if.rsp_valid}, 32'd1);
    bus_if.req_re = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr.async_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("rr.async_rdata", bus_if.rsp_rdata, 32'd0);
    chk("rr.async_io",    {24'd0, io_out}, 32'd0);
    chk("rr.async_ready", {31'd0, bus_if.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rr.no_pulse", {31'd0, bus_if.rsp_valid}, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 3'b010, 32'h1122_3344, 1'b0, "lw0_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
